// File: rtl/thee_pga_agc_pkg.sv
// Shared types and defaults for the PGA automatic gain controller.
package thee_pga_agc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    ADJUST  = 2'd3
  } agc_state_t;

  localparam int DEF_HI_THR        = 200;
  localparam int DEF_LO_THR        = 64;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_WIN_SAMPLES   = 4;
  localparam int CNT_BITS          = 16;

endpackage

// File: rtl/thee_pga_agc_ctrl_if.sv
// Bus between the ADC magnitude path, the AGC and the amplifier gain input.
// Optional manual override ports exist only when THEE_PGA_AGC_MANUAL_EN is defined.
interface thee_pga_agc_ctrl_if #(
  parameter int GAIN_BITS = 3,
  parameter int MAG_BITS  = 8
);
  // sample_valid qualifies sample_mag for exactly one cycle; there is no
  // back-pressure, so every valid cycle seen in MEASURE is consumed.
  logic                          en;
  logic                          sample_valid;
  logic [MAG_BITS-1:0]           sample_mag;
  logic [GAIN_BITS-1:0]          dig_gain;
  logic                          gain_update;
  logic                          locked;
  logic                          range_err;
  thee_pga_agc_pkg::agc_state_t  state;
`ifdef THEE_PGA_AGC_MANUAL_EN
  logic                          man_en;
  logic [GAIN_BITS-1:0]          man_gain;

  modport master (output en, sample_valid, sample_mag, man_en, man_gain,
                  input  dig_gain, gain_update, locked, range_err, state);
  modport slave  (input  en, sample_valid, sample_mag, man_en, man_gain,
                  output dig_gain, gain_update, locked, range_err, state);
`else
  modport master (output en, sample_valid, sample_mag,
                  input  dig_gain, gain_update, locked, range_err, state);
  modport slave  (input  en, sample_valid, sample_mag,
                  output dig_gain, gain_update, locked, range_err, state);
`endif
endinterface

// File: rtl/thee_pga_peak_win.sv
// Measurement window: counts valid samples and tracks their peak magnitude.
module thee_pga_peak_win
  import thee_pga_agc_pkg::*;
#(
  parameter int MAG_BITS    = 8,
  parameter int WIN_SAMPLES = DEF_WIN_SAMPLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                valid,
  input  logic [MAG_BITS-1:0] mag,
  output logic [MAG_BITS-1:0] peak,
  output logic                done
);

  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(WIN_SAMPLES - 1);

  logic [CNT_BITS-1:0] cnt;

  // done fires in the cycle the last sample is accepted; peak already
  // includes that sample on the following cycle.
  assign done = valid && !clear && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      peak <= '0;
    end else if (clear) begin
      cnt  <= '0;
      peak <= '0;
    end else if (valid) begin
      peak <= (mag > peak) ? mag : peak;
      cnt  <= done ? '0 : cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/thee_pga_agc_ctrl.sv
// AGC sequencer: settle, measure a window, step the gain one LSB toward the window.
// Define THEE_PGA_AGC_MANUAL_EN to add the man_en/man_gain override.
module thee_pga_agc_ctrl
  import thee_pga_agc_pkg::*;
#(
  parameter int GAIN_BITS     = 3,
  parameter int MAG_BITS      = 8,
  parameter int GAIN_INIT     = 0,
  parameter int HI_THR        = DEF_HI_THR,
  parameter int LO_THR        = DEF_LO_THR,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int WIN_SAMPLES   = DEF_WIN_SAMPLES
) (
  input logic              clk,
  input logic              rst,
  thee_pga_agc_ctrl_if.slave bus
);

  localparam logic [MAG_BITS-1:0]  HI_T        = MAG_BITS'(HI_THR);
  localparam logic [MAG_BITS-1:0]  LO_T        = MAG_BITS'(LO_THR);
  localparam logic [GAIN_BITS-1:0] GAIN_MAX    = '1;
  localparam logic [GAIN_BITS-1:0] GAIN_RST    = GAIN_BITS'(GAIN_INIT);
  localparam logic [CNT_BITS-1:0]  SETTLE_LAST = CNT_BITS'(SETTLE_CYCLES - 1);

  agc_state_t           state;
  logic [CNT_BITS-1:0]  settle_cnt;
  logic [GAIN_BITS-1:0] gain;
  logic                 gain_update;
  logic                 locked;
  logic                 range_err;
  logic [MAG_BITS-1:0]  peak;
  logic                 win_done;
  logic                 step_dn;
  logic                 step_up;
  logic                 in_range;
  logic                 man_active;
  logic [GAIN_BITS-1:0] man_gain;

`ifdef THEE_PGA_AGC_MANUAL_EN
  assign man_active = bus.man_en;
  assign man_gain   = bus.man_gain;
`else
  assign man_active = 1'b0;
  assign man_gain   = gain;
`endif

  thee_pga_peak_win #(
    .MAG_BITS    (MAG_BITS),
    .WIN_SAMPLES (WIN_SAMPLES)
  ) u_peak_win (
    .clk   (clk),
    .rst   (rst),
    .clear (state != MEASURE),
    .valid (bus.sample_valid),
    .mag   (bus.sample_mag),
    .peak  (peak),
    .done  (win_done)
  );

  always_comb begin
    step_dn  = (peak > HI_T) && (gain != '0);
    step_up  = (peak < LO_T) && (gain != GAIN_MAX);
    in_range = (peak >= LO_T) && (peak <= HI_T);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      gain        <= GAIN_RST;
      gain_update <= 1'b0;
      locked      <= 1'b0;
      range_err   <= 1'b0;
    end else if (man_active) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      gain        <= man_gain;
      gain_update <= (man_gain != gain);
      locked      <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      gain_update <= 1'b0;
      case (state)
        IDLE: begin
          settle_cnt <= '0;
          if (bus.en) state <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= MEASURE;
          end else begin
            settle_cnt <= settle_cnt + CNT_BITS'(1);
          end
        end
        MEASURE: begin
          if (win_done) state <= ADJUST;
        end
        ADJUST: begin
          if (step_dn || step_up) begin
            gain        <= step_dn ? gain - GAIN_BITS'(1) : gain + GAIN_BITS'(1);
            gain_update <= 1'b1;
            locked      <= 1'b0;
            range_err   <= 1'b0;
            state       <= SETTLE;
          end else begin
            // no step possible: either in the window or pinned at a code limit
            locked    <= in_range;
            range_err <= !in_range;
            state     <= MEASURE;
          end
        end
        default: state <= IDLE;
      endcase
      // disable wins over every state, but a step decided this cycle still lands
      if (!bus.en) begin
        state      <= IDLE;
        settle_cnt <= '0;
        locked     <= 1'b0;
        range_err  <= 1'b0;
      end
    end
  end

  assign bus.dig_gain    = gain;
  assign bus.gain_update = gain_update;
  assign bus.locked      = locked;
  assign bus.range_err   = range_err;
  assign bus.state       = state;

endmodule

// File: tb/tb_thee_pga_agc_ctrl.sv
// Self-checking bench for thee_pga_agc_ctrl with a window-level reference model.
// Manual override scenario is compiled when THEE_PGA_AGC_MANUAL_EN is defined.
module tb_thee_pga_agc_ctrl;
  import thee_pga_agc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  thee_pga_agc_ctrl_if bus ();
  thee_pga_agc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int pass_cnt  = 0;
  int total_cnt = 0;

  // reference model state
  int         exp_gain;
  logic       exp_changed;
  logic [2:0] exp_flags;               // {gain_update, locked, range_err}
  logic [7:0] exp_q[$];                // samples of the window about to be driven

  task automatic cyc(input logic en, input logic v, input logic [7:0] m);
    bus.en = en;
    bus.sample_valid = v;
    bus.sample_mag = m;
    @(posedge clk);
    #1;
  endtask

  // Spec rules for one completed window, applied to the model
  task automatic model_window(input int pk);
    exp_changed = 1'b0;
    if (pk > 200 && exp_gain > 0) begin
      exp_gain = exp_gain - 1; exp_changed = 1'b1; exp_flags = 3'b100;
    end else if (pk < 64 && exp_gain < 7) begin
      exp_gain = exp_gain + 1; exp_changed = 1'b1; exp_flags = 3'b100;
    end else if (pk >= 64 && pk <= 200) begin
      exp_flags = 3'b010;
    end else begin
      exp_flags = 3'b001;
    end
  endtask

  task automatic do_reset();
    bus.en = 1'b0; bus.sample_valid = 1'b0; bus.sample_mag = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({bus.dig_gain, bus.gain_update, bus.locked, bus.range_err} !== 6'b000_000 || bus.state !== IDLE)
      $display("FAIL reset_async: got gain=%0d flags=%b%b%b state=%0d want gain=0 flags=000 state=0",
               bus.dig_gain, bus.gain_update, bus.locked, bus.range_err, bus.state);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_gain = 0;
  endtask

  // From IDLE: enable, then the settle period with samples that must be ignored
  task automatic start_agc(input logic [7:0] junk);
    cyc(1'b1, 1'b0, 8'd0);
    repeat (4) cyc(1'b1, 1'b1, junk);
    total_cnt++;
    if (bus.state !== MEASURE)
      $display("FAIL start_measure: got state=%0d want %0d", bus.state, MEASURE);
    else pass_cnt++;
  endtask

  // Drives exp_q as one window (optionally with invalid gaps), the ADJUST cycle,
  // checks the outcome, then runs settle_n settle cycles if the gain moved.
  task automatic run_window(input string tag, input bit gaps, input int settle_n);
    int pk = 0;
    foreach (exp_q[i]) if (int'(exp_q[i]) > pk) pk = int'(exp_q[i]);
    while (exp_q.size() > 0) begin
      if (gaps && $urandom_range(0, 2) == 0) cyc(1'b1, 1'b0, 8'($urandom_range(0, 255)));
      else cyc(1'b1, 1'b1, exp_q.pop_front());
    end
    cyc(1'b1, 1'b1, 8'($urandom_range(0, 255)));
    model_window(pk);
    total_cnt++;
    if (bus.dig_gain !== 3'(exp_gain))
      $display("FAIL %s_gain: got %0d want %0d (peak %0d)", tag, bus.dig_gain, exp_gain, pk);
    else pass_cnt++;
    total_cnt++;
    if ({bus.gain_update, bus.locked, bus.range_err} !== exp_flags)
      $display("FAIL %s_flags: got upd/lock/rerr=%b%b%b want %b (peak %0d)", tag,
               bus.gain_update, bus.locked, bus.range_err, exp_flags, pk);
    else pass_cnt++;
    if (exp_changed) begin
      for (int s = 0; s < settle_n; s++) begin
        cyc(1'b1, 1'b1, 8'd255);
        if (s == 0) begin
          total_cnt++;
          if (bus.gain_update !== 1'b0)
            $display("FAIL %s_pulse_len: got gain_update=%b want 0", tag, bus.gain_update);
          else pass_cnt++;
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      total_cnt++;
      if ({bus.dig_gain, bus.gain_update, bus.locked, bus.range_err} !== 6'b0 || bus.state !== IDLE)
        $display("FAIL idle_hold: got gain=%0d flags=%b%b%b state=%0d want all 0", bus.dig_gain,
                 bus.gain_update, bus.locked, bus.range_err, bus.state);
      else pass_cnt++;
    end
  endtask

  task automatic test_ramp();
    int pulses = 0;
    do_reset();
    for (int c = 1; c <= 73; c++) begin
      cyc(1'b1, 1'b1, 8'd10);
      if (bus.gain_update) begin
        pulses++;
        total_cnt++;
        if (c != 10 + 9 * (pulses - 1) || bus.dig_gain !== 3'(pulses))
          $display("FAIL ramp_step: got pulse at cycle %0d gain %0d want cycle %0d gain %0d",
                   c, bus.dig_gain, 10 + 9 * (pulses - 1), pulses);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (pulses != 7) $display("FAIL ramp_count: got %0d steps want 7", pulses);
    else pass_cnt++;
    total_cnt++;
    if (bus.dig_gain !== 3'd7 || bus.range_err !== 1'b1 || bus.locked !== 1'b0)
      $display("FAIL ramp_limit: got gain=%0d rerr=%b locked=%b want 7 1 0",
               bus.dig_gain, bus.range_err, bus.locked);
    else pass_cnt++;
    exp_gain = 7;
  endtask

  task automatic test_lock();
    do_reset();
    start_agc(8'd255);
    repeat (3) begin
      exp_q = '{8'd10, 8'd20, 8'd5, 8'd30};
      run_window("lock_ramp", 1'b0, 4);
    end
    exp_q = '{8'd100, 8'd100, 8'd100, 8'd100};
    run_window("lock_100", 1'b0, 4);
    exp_q = '{8'd64, 8'd64, 8'd64, 8'd64};
    run_window("lock_64", 1'b0, 4);
    exp_q = '{8'd150, 8'd200, 8'd80, 8'd64};
    run_window("lock_200", 1'b0, 4);
  endtask

  task automatic test_step_down();
    do_reset();
    start_agc(8'd255);
    repeat (5) begin
      exp_q = '{8'd1, 8'd2, 8'd3, 8'd4};
      run_window("dn_ramp", 1'b0, 4);
    end
    exp_q = '{8'd50, 8'd250, 8'd50, 8'd50};
    run_window("step_down", 1'b0, 4);
    exp_q = '{8'd100, 8'd120, 8'd90, 8'd100};
    run_window("dn_after", 1'b0, 4);
  endtask

  task automatic test_abort();
    // locked at gain 4 in MEASURE: drop en
    cyc(1'b0, 1'b1, 8'd10);
    total_cnt++;
    if (bus.state !== IDLE || bus.dig_gain !== 3'(exp_gain) || bus.locked !== 1'b0 || bus.range_err !== 1'b0)
      $display("FAIL abort_measure: got state=%0d gain=%0d lock=%b rerr=%b want 0 %0d 0 0",
               bus.state, bus.dig_gain, bus.locked, bus.range_err, exp_gain);
    else pass_cnt++;
    start_agc(8'd10);
    exp_q = '{8'd50, 8'd10, 8'd20, 8'd30};
    run_window("abort_up", 1'b0, 2);
    cyc(1'b0, 1'b1, 8'd10);
    total_cnt++;
    if (bus.state !== IDLE || bus.dig_gain !== 3'(exp_gain) || bus.locked !== 1'b0 || bus.range_err !== 1'b0)
      $display("FAIL abort_settle: got state=%0d gain=%0d lock=%b rerr=%b want 0 %0d 0 0",
               bus.state, bus.dig_gain, bus.locked, bus.range_err, exp_gain);
    else pass_cnt++;
    cyc(1'b0, 1'b0, 8'd0);
    start_agc(8'd10);
    exp_q = '{8'd100, 8'd100, 8'd100, 8'd100};
    run_window("abort_resume", 1'b0, 4);
  endtask

  task automatic test_random();
    do_reset();
    start_agc(8'($urandom_range(0, 255)));
    for (int w = 0; w < 40; w++) begin
      int thr;
      exp_q = {};
      case ($urandom_range(0, 4))
        0: repeat (4) exp_q.push_back(8'($urandom_range(0, 63)));
        1: repeat (4) exp_q.push_back(8'($urandom_range(64, 200)));
        2: begin
          repeat (3) exp_q.push_back(8'($urandom_range(0, 255)));
          exp_q.push_back(8'($urandom_range(201, 255)));
        end
        3: begin
          thr = ($urandom_range(0, 1) == 0) ? 64 : 200;
          exp_q.push_back(8'(thr));
          repeat (3) exp_q.push_back(8'($urandom_range(0, thr)));
        end
        default: repeat (4) exp_q.push_back(8'($urandom_range(0, 255)));
      endcase
      run_window("rand", 1'b1, 4);
    end
  endtask

  task automatic test_reset_mid_window();
    cyc(1'b1, 1'b1, 8'd30);
    cyc(1'b1, 1'b1, 8'd30);
    do_reset();
  endtask

`ifdef THEE_PGA_AGC_MANUAL_EN
  task automatic test_manual();
    do_reset();
    start_agc(8'd255);
    exp_q = '{8'd10, 8'd10, 8'd10, 8'd10};
    run_window("man_pre", 1'b0, 4);
    bus.man_en = 1'b1; bus.man_gain = 3'd6;
    cyc(1'b1, 1'b1, 8'd10);
    total_cnt++;
    if (bus.dig_gain !== 3'd6 || bus.gain_update !== 1'b1 || bus.state !== IDLE || bus.locked || bus.range_err)
      $display("FAIL manual_set: got gain=%0d upd=%b state=%0d want 6 1 0",
               bus.dig_gain, bus.gain_update, bus.state);
    else pass_cnt++;
    cyc(1'b1, 1'b1, 8'd10);
    total_cnt++;
    if (bus.dig_gain !== 3'd6 || bus.gain_update !== 1'b0 || bus.state !== IDLE)
      $display("FAIL manual_hold: got gain=%0d upd=%b state=%0d want 6 0 0",
               bus.dig_gain, bus.gain_update, bus.state);
    else pass_cnt++;
    bus.man_en = 1'b0;
    exp_gain = 6;
    start_agc(8'd10);
    exp_q = '{8'd100, 8'd100, 8'd100, 8'd100};
    run_window("manual_resume", 1'b0, 4);
  endtask
`endif

  initial begin
    bus.en = 1'b0; bus.sample_valid = 1'b0; bus.sample_mag = '0;
`ifdef THEE_PGA_AGC_MANUAL_EN
    bus.man_en = 1'b0; bus.man_gain = '0;
`endif
    exp_gain = 0;
    exp_changed = 1'b0;
    exp_flags = '0;
    test_reset();
    test_ramp();
    test_lock();
    test_step_down();
    test_abort();
    test_random();
    test_reset_mid_window();
`ifdef THEE_PGA_AGC_MANUAL_EN
    test_manual();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/thee_pga_agc_ctrl.md
# thee_pga_agc_ctrl

Automatic gain controller that sequences the digital gain code of the programmable-gain amplifier. It watches the digitized magnitude of the amplifier output and steps the gain code up or down one LSB at a time until the peak sits inside a threshold window. It sits between the ADC magnitude path and the amplifier's `dig_gain` input, with a settling delay after every gain change.

## Interface
- `GAIN_BITS`, 3: gain code width; codes 0..2^GAIN_BITS-1.
- `MAG_BITS`, 8: unsigned sample magnitude width.
- `GAIN_INIT`, 0: gain code after reset.
- `HI_THR`, 200: peak strictly above this requests gain-1.
- `LO_THR`, 64: peak strictly below this requests gain+1. Must satisfy LO_THR < HI_THR.
- `SETTLE_CYCLES`, 4: clock cycles ignored after a gain change, 1..65535.
- `WIN_SAMPLES`, 4: valid samples per measurement window, 1..65535.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `en`  in  1: AGC enable, level.
- `sample_valid`  in  1: `sample_mag` qualifier.
- `sample_mag`  in  MAG_BITS: unsigned magnitude of amplifier output.
- `dig_gain`  out  GAIN_BITS: registered gain code to amplifier.
- `gain_update`  out  1: one-cycle pulse in the first cycle a new `dig_gain` is visible.
- `locked`  out  1: last window was in range with no change.
- `range_err`  out  1: last window requested a step beyond code 0 or max.

## Operation
- States: IDLE, SETTLE, MEASURE, ADJUST.
- IDLE: all counters are cleared. `dig_gain` holds its current value. When `en`=1, go to SETTLE.
- SETTLE: counts SETTLE_CYCLES cycles and ignores samples, then goes to MEASURE.
- MEASURE:
  - Each cycle with `sample_valid`=1 increments the sample count and updates peak = max(peak, `sample_mag`).
  - After the WIN_SAMPLES-th valid sample is accepted, go to ADJUST.
  - The peak clears on entry.
- ADJUST (exactly one cycle, samples ignored):
  - If peak > HI_THR and gain > 0: gain-1.
  - Else if peak < LO_THR and gain < max: gain+1.
  - Else no change.
  - On change: `locked`←0, `range_err`←0, go to SETTLE.
  - No change, peak in [LO_THR, HI_THR]: `locked`←1, `range_err`←0, go to MEASURE.
  - No change because the code is at a limit: `locked`←0, `range_err`←1, go to MEASURE.
- `en`=0 in any state: IDLE next cycle. `locked`←0, `range_err`←0, and the gain is retained. Re-enabling always begins with a full SETTLE.
- Comparisons are unsigned and strict; peak equal to either threshold is in range. The gain never wraps.

## Timing
- Reset values: `dig_gain`=GAIN_INIT, `gain_update`=0, `locked`=0, `range_err`=0, state IDLE. Reset takes effect immediately, including mid-window.
- ADJUST in cycle N:
  - New `dig_gain` and `gain_update`=1 appear in N+1.
  - SETTLE occupies N+1..N+SETTLE_CYCLES.
  - MEASURE is entered at N+SETTLE_CYCLES+1.
- Minimum loop period: 1 (ADJUST) + SETTLE_CYCLES + WIN_SAMPLES cycles (with `sample_valid` always high).
- `locked` and `range_err` update in the cycle after ADJUST and hold until the next ADJUST, `en`=0, or reset.
- If `en` falls in the same cycle as ADJUST, the gain step still applies and the state goes to IDLE.

## Configuration
- `THEE_PGA_AGC_MANUAL_EN`
- Defined:
  - Adds inputs `man_en` (1 bit) and `man_gain` (GAIN_BITS).
  - While `man_en`=1: `dig_gain`←`man_gain` every cycle, the FSM is forced to IDLE, and `locked`/`range_err` are 0.
  - `gain_update` pulses only when `man_gain` differs from the current code.
  - `man_en` has priority over `en`.
- Undefined: the ports are absent and behaviour is purely automatic.

## Structure
- Package `thee_pga_agc_pkg`:
  - State enum typedef `agc_state_t`.
  - Default threshold/settle/window constants.
  - Counter width constant (16).
- Sub-module `thee_pga_peak_win`:
  - Inputs: clear, valid, magnitude.
  - Outputs: peak and window-done.
  - Holds the sample counter and the peak register.
- The top level holds the FSM, settle counter and gain register.

## Test plan
All scenarios use default parameters.
- Reset/idle: assert `rst` asynchronously between edges → `dig_gain`=0 and all flags 0 immediately. With `en`=0 and samples toggling, nothing changes.
- Ramp up: `en`=1, `sample_mag`=10 every cycle:
  - Gain steps 0→1→…→7, one step every 9 cycles, with a `gain_update` pulse each step.
  - At 7, the next ADJUST gives `range_err`=1, `locked`=0, gain stays 7.
- Lock: gain 3, `sample_mag`=100 → after the first window `locked`=1, no `gain_update`, gain stays 3. Peaks of exactly 64 and exactly 200 also lock.
- Step down: gain 5, window {50,250,50,50} → gain 4 one cycle after ADJUST, `gain_update`=1 for one cycle. The next 4 cycles' samples (mag 255) are ignored.
- Abort: drop `en` mid-SETTLE → IDLE next cycle, gain held, flags 0. Re-raise `en` → the full 4-cycle SETTLE restarts before any sample counts.
- Manual (macro defined): `man_en`=1, `man_gain`=6 during MEASURE → `dig_gain`=6 next cycle with `gain_update` pulse and state IDLE. Release → AGC resumes from 6 via SETTLE.
